bact_ternary_quant: RTL

- Stage directly downstream of the binary-convolution output stage.
- Takes the ReLU'd, scaled WIDTH_O-bit activation stream and adds a per-channel signed bias.
- Quantizes each result to a 2-bit ternary code (00 = zero, 01 = +1, 11 = -1), the same encoding the next binary conv consumes.
- Passes the hsync/reuse/valid framing through, aligned with the data.

---
 rtl/bact_ternary_quant.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/bact_ternary_quant.sv
// Ternary quantizer: adds a per-channel bias to each activation and emits a 2-bit code
// (00 zero, 01 +1, 11 -1) three cycles later. Define BACT_STAT_EN to enable the code counters.
module bact_ternary_quant #(
    parameter int WIDTH_O = 27,
    parameter int WIDTH_B = 16,
    parameter int WIDTH_D = 2,
    parameter int CHANNEL = 256,
    parameter int SIZE    = 56
) (
    input  logic               i_sclk,
    input  logic               i_vsync,
    input  logic               i_hsync,
    input  logic               i_reuse,
    input  logic               i_valid,
    input  logic [WIDTH_O-1:0] i_tdata,
    input  logic               i_bias_vld,
    input  logic [WIDTH_B-1:0] i_bias,
    input  logic [WIDTH_O-2:0] i_thr,
    output logic               o_hsync,
    output logic               o_reuse,
    output logic               o_valid,
    output logic [WIDTH_D-1:0] o_tdata,
    output logic [1:0]         o_err,
    output logic [31:0]        o_cnt_pos,
    output logic [31:0]        o_cnt_neg
);
    localparam int CW   = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;
    localparam int DW   = WIDTH_O + 1;
    localparam int CMPW = WIDTH_O + 2;
    localparam logic [CW-1:0] CH_LAST = CW'(CHANNEL - 1);
    localparam logic [WIDTH_D-1:0] CODE_POS = WIDTH_D'(1);
    localparam logic [WIDTH_D-1:0] CODE_NEG = '1;

    logic [WIDTH_B-1:0] tbl_q [CHANNEL];
    logic               tbl_we;

    logic [CW-1:0]        ptr_q, ptr_d, ch_q, ch_d;
    logic                 tbl_full_q, tbl_full_d;
    logic [1:0]           err_q, err_d;
    logic [2:0]           vld_pipe_q, vld_pipe_d;
    logic [2:0]           hs_pipe_q, hs_pipe_d;
    logic [2:0]           ru_pipe_q, ru_pipe_d;
    logic [WIDTH_O-1:0]   x_q, x_d;
    logic [WIDTH_B-1:0]   b_q, b_d;
    logic signed [DW-1:0] d_q, d_d;
    logic [WIDTH_D-1:0]   code_q, code_d;

    logic signed [CMPW-1:0] d_ext, t_ext, neg_t;

    always_comb begin
        ptr_d      = ptr_q;
        tbl_full_d = tbl_full_q;
        tbl_we     = 1'b0;
        err_d      = err_q;
        ch_d       = ch_q;

        // Once the table is full the pointer parks on the last slot; extra loads only flag.
        if (i_bias_vld) begin
            if (!tbl_full_q) begin
                tbl_we = 1'b1;
                if (ptr_q == CH_LAST) tbl_full_d = 1'b1;
                else                  ptr_d      = ptr_q + 1'b1;
            end else begin
                err_d[1] = 1'b1;
            end
        end
        if (i_valid && !tbl_full_q) err_d[0] = 1'b1;

        if (i_hsync)      ch_d = CH_LAST;
        else if (i_reuse) ch_d = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;

        vld_pipe_d = {vld_pipe_q[1:0], i_valid};
        hs_pipe_d  = {hs_pipe_q[1:0], i_hsync};
        ru_pipe_d  = {ru_pipe_q[1:0], i_reuse};

        x_d = i_tdata;
        b_d = tbl_q[ch_q];
        d_d = $signed({x_q[WIDTH_O-1], x_q})
            + $signed({{(DW - WIDTH_B){b_q[WIDTH_B-1]}}, b_q});

        // Threshold is unsigned; widen by one more bit so -T never overflows.
        d_ext  = $signed({d_q[DW-1], d_q});
        t_ext  = $signed({3'b000, i_thr});
        neg_t  = -t_ext;
        code_d = '0;
        if (vld_pipe_q[1]) begin
            if (d_ext > t_ext)      code_d = CODE_POS;
            else if (d_ext < neg_t) code_d = CODE_NEG;
        end
    end

    always_ff @(posedge i_sclk) begin
        if (i_vsync) begin
            ptr_q      <= '0;
            tbl_full_q <= 1'b0;
            err_q      <= '0;
            ch_q       <= CH_LAST;
            vld_pipe_q <= '0;
            hs_pipe_q  <= '0;
            ru_pipe_q  <= '0;
            x_q        <= '0;
            b_q        <= '0;
            d_q        <= '0;
            code_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            tbl_full_q <= tbl_full_d;
            err_q      <= err_d;
            ch_q       <= ch_d;
            vld_pipe_q <= vld_pipe_d;
            hs_pipe_q  <= hs_pipe_d;
            ru_pipe_q  <= ru_pipe_d;
            x_q        <= x_d;
            b_q        <= b_d;
            d_q        <= d_d;
            code_q     <= code_d;
        end
    end

    always_ff @(posedge i_sclk) begin
        if (tbl_we && !i_vsync) tbl_q[ptr_q] <= i_bias;
    end

    assign o_hsync = hs_pipe_q[2];
    assign o_reuse = ru_pipe_q[2];
    assign o_valid = vld_pipe_q[2];
    assign o_tdata = code_q;
    assign o_err   = err_q;

`ifdef BACT_STAT_EN
    logic [31:0] cnt_pos_q, cnt_pos_d, cnt_neg_q, cnt_neg_d;

    always_comb begin
        cnt_pos_d = cnt_pos_q;
        cnt_neg_d = cnt_neg_q;
        if (vld_pipe_q[2] && code_q == CODE_POS && cnt_pos_q != '1) cnt_pos_d = cnt_pos_q + 1'b1;
        if (vld_pipe_q[2] && code_q == CODE_NEG && cnt_neg_q != '1) cnt_neg_d = cnt_neg_q + 1'b1;
    end

    always_ff @(posedge i_sclk) begin
        if (i_vsync) begin
            cnt_pos_q <= '0;
            cnt_neg_q <= '0;
        end else begin
            cnt_pos_q <= cnt_pos_d;
            cnt_neg_q <= cnt_neg_d;
        end
    end

    assign o_cnt_pos = cnt_pos_q;
    assign o_cnt_neg = cnt_neg_q;
`else
    assign o_cnt_pos = '0;
    assign o_cnt_neg = '0;
`endif

endmodule
